// File: rtl/seg7_scan_mux_if.sv
// Digit register-file write port for seg7_scan_mux.
// The master drives one write per cycle, and the slave always accepts it.
interface seg7_scan_mux_if #(
    parameter int NDIGITS = 4
) ();
    localparam int AW = $clog2(NDIGITS);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_data;
    logic          wr_dp;

    modport master (output wr_en, output wr_addr, output wr_data, output wr_dp);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data, input  wr_dp);
endinterface

// File: rtl/seg7_scan_mux.sv
// Multiplexed 7-segment scan driver with a per-digit code/dp register file,
// an anti-ghost blank interval, leading-zero blanking and optional blink (SEG7_BLINK_EN).
module seg7_scan_mux #(
    parameter int NDIGITS   = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 2,
    parameter int BLINK_DIV = 256
) (
    input  logic                       clk_2,
    input  logic                       reset,
    seg7_scan_mux_if.slave             wr,
    input  logic                       lzb,
    input  logic [NDIGITS-1:0]         blink_mask,
    output logic [7:0]                 SEG,
    output logic [NDIGITS-1:0]         DIG,
    output logic [$clog2(NDIGITS)-1:0] cur_digit
);
    localparam int AW = $clog2(NDIGITS);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [AW-1:0] IDX_LAST  = AW'(NDIGITS - 1);

    logic [3:0]         code_q [NDIGITS];
    logic [NDIGITS-1:0] dp_q;
    logic [CW-1:0]      scan_cnt;
    logic [AW-1:0]      idx;
    logic               slot_end;
    logic               round_end;
    logic               in_blank;
    logic               blink_off;
    logic               zero_run;
    logic [NDIGITS-1:0] lz_blank;
    logic               digit_off;
    logic [7:0]         seg_next;
    logic [NDIGITS-1:0] dig_next;

    function automatic logic [6:0] glyph(input logic [3:0] h);
        glyph = 7'h00;
        case (h)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            4'hF: glyph = 7'h71;
            default: glyph = 7'h00;
        endcase
    endfunction

    assign slot_end  = (scan_cnt == SCAN_LAST);
    assign round_end = slot_end && (idx == IDX_LAST);

    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (scan_cnt < CW'(BLANK_CYC));
        end
    endgenerate

`ifdef SEG7_BLINK_EN
    localparam int RW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] ROUND_LAST = RW'(BLINK_DIV - 1);

    logic [RW-1:0] round_cnt;
    logic          blink_phase;

    // Rounds are counted on the idx wrap, so a blink half-period is whole scan rounds.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            round_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (round_end) begin
            if (round_cnt == ROUND_LAST) begin
                round_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                round_cnt <= round_cnt + 1'b1;
            end
        end
    end

    assign blink_off = blink_phase & blink_mask[idx];
`else
    localparam int unused_blink_div = BLINK_DIV;
    logic unused_blink_mask;
    assign unused_blink_mask = ^blink_mask;
    assign blink_off = 1'b0;
`endif

    // A digit is a leading zero when it and every more significant digit hold 0.
    always_comb begin
        zero_run = 1'b1;
        lz_blank = '0;
        for (int k = NDIGITS - 1; k >= 1; k--) begin
            zero_run    = zero_run & (code_q[k] == 4'h0);
            lz_blank[k] = zero_run;
        end
    end

    assign digit_off = (lzb & lz_blank[idx]) | blink_off;

    always_comb begin
        dig_next = '0;
        seg_next = '0;
        if (!in_blank) begin
            dig_next = NDIGITS'(1) << idx;
            if (!digit_off) begin
                seg_next = {dp_q[idx], glyph(code_q[idx])};
            end
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            scan_cnt  <= '0;
            idx       <= '0;
            cur_digit <= '0;
            SEG       <= '0;
            DIG       <= '0;
            dp_q      <= '0;
            for (int i = 0; i < NDIGITS; i++) begin
                code_q[i] <= 4'h0;
            end
        end else begin
            if (slot_end) begin
                scan_cnt <= '0;
                idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            cur_digit <= idx;
            SEG       <= seg_next;
            DIG       <= dig_next;
            // Decoded per-entry compare drops any address beyond the last digit.
            for (int i = 0; i < NDIGITS; i++) begin
                if (wr.wr_en && (wr.wr_addr == AW'(i))) begin
                    code_q[i] <= wr.wr_data;
                    dp_q[i]   <= wr.wr_dp;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux: 4 digits, 8-cycle slots, 2 blank cycles.
// Every change of {SEG,DIG} is popped against a queued event (cycle, seg, dig, cur_digit).
module tb_seg7_scan_mux;
    logic       clk_2 = 1'b0;
    logic       reset = 1'b1;
    logic       lzb   = 1'b0;
    logic [3:0] blink_mask = 4'b0000;
    logic [7:0] SEG;
    logic [3:0] DIG;
    logic [1:0] cur_digit;

    seg7_scan_mux_if #(.NDIGITS(4)) wr_bus ();

    seg7_scan_mux #(
        .NDIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .BLINK_DIV(2)
    ) dut (
        .clk_2(clk_2), .reset(reset), .wr(wr_bus), .lzb(lzb),
        .blink_mask(blink_mask), .SEG(SEG), .DIG(DIG), .cur_digit(cur_digit)
    );

    always #5 clk_2 = ~clk_2;

    typedef struct {
        int         cyc;
        logic [7:0] seg;
        logic [3:0] dig;
        logic [1:0] cur;
    } ev_t;

    ev_t        sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc;
    bit         mon_en   = 1'b0;
    logic [11:0] prev_out = '0;

    // Edge n after reset release is counted as cyc == n.
    always @(posedge clk_2 or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk_2) begin
        if (!mon_en) begin
            prev_out = {SEG, DIG};
        end else if ({SEG, DIG} != prev_out) begin
            prev_out = {SEG, DIG};
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got SEG=%h DIG=%b at cyc %0d expected none", SEG, DIG, cyc);
            end else begin
                ev_t e;
                e = sb_q.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("seg", {24'd0, SEG}, {24'd0, e.seg});
                chk("dig", {28'd0, DIG}, {28'd0, e.dig});
                chk("cur_digit", {30'd0, cur_digit}, {30'd0, e.cur});
            end
        end
    end

    task automatic push_ev(input int c, input logic [7:0] s, input logic [3:0] d, input logic [1:0] cu);
        ev_t e;
        e.cyc = c; e.seg = s; e.dig = d; e.cur = cu;
        sb_q.push_back(e);
    endtask

    // Slot d of round r: blank starts on edge 32r+8d+1, digit driven from edge 32r+8d+3.
    task automatic push_slot(input int r, input int d, input logic [7:0] s, input bit skip_blank);
        if (!skip_blank) push_ev(32*r + 8*d + 1, 8'h00, 4'b0000, 2'(d));
        push_ev(32*r + 8*d + 3, s, 4'b0001 << d, 2'(d));
    endtask

    task automatic push_round(input int r, input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3, input bit skip0);
        push_slot(r, 0, s0, skip0);
        push_slot(r, 1, s1, 1'b0);
        push_slot(r, 2, s2, 1'b0);
        push_slot(r, 3, s3, 1'b0);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        reset  = 1'b1;
        wr_bus.wr_en = 1'b0;
        repeat (3) @(negedge clk_2);
        reset = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [3:0] d, input logic dp);
        wr_bus.wr_en   = 1'b1;
        wr_bus.wr_addr = a;
        wr_bus.wr_data = d;
        wr_bus.wr_dp   = dp;
        @(posedge clk_2);
        #1;
        wr_bus.wr_en = 1'b0;
    endtask

    task automatic write_all(input logic [3:0] c3, input logic [3:0] c2, input logic [3:0] c1,
                             input logic [3:0] c0, input logic [3:0] dpm);
        do_write(2'd3, c3, dpm[3]);
        do_write(2'd2, c2, dpm[2]);
        do_write(2'd1, c1, dpm[1]);
        do_write(2'd0, c0, dpm[0]);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk_2);
            #1;
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(posedge clk_2);
        chk(name, sb_q.size(), 0);
        sb_q.delete();
        mon_en = 1'b0;
    endtask

    initial begin
        wr_bus.wr_en = 1'b0; wr_bus.wr_addr = '0; wr_bus.wr_data = '0; wr_bus.wr_dp = 1'b0;
        #2;
        chk("reset_seg", {24'd0, SEG}, 32'd0);
        chk("reset_dig", {28'd0, DIG}, 32'd0);
        chk("reset_cur", {30'd0, cur_digit}, 32'd0);

        // Digits 3..0 = 1,2,3,4, plain scan over two rounds.
        do_reset();
        lzb = 1'b0;
        write_all(4'h1, 4'h2, 4'h3, 4'h4, 4'b0000);
        push_round(1, 8'h66, 8'h4F, 8'h5B, 8'h06, 1'b0);
        push_round(2, 8'h66, 8'h4F, 8'h5B, 8'h06, 1'b0);
        wait_cyc(32);
        mon_en = 1'b1;
        drain("scan_drain");

        // Codes {0,0,5,0}: LZB on for round 1, off for round 2.
        do_reset();
        lzb = 1'b1;
        write_all(4'h0, 4'h0, 4'h5, 4'h0, 4'b0000);
        push_round(1, 8'h3F, 8'h6D, 8'h00, 8'h00, 1'b0);
        push_round(2, 8'h3F, 8'h6D, 8'h3F, 8'h3F, 1'b0);
        wait_cyc(32);
        mon_en = 1'b1;
        wait_cyc(64);
        lzb = 1'b0;
        drain("lzb_drain");

        // dp on digit 2; code A into digit 0 mid-slot. Code reg takes it on edge 69,
        // the output register on edge 70.
        do_reset();
        write_all(4'h0, 4'h0, 4'h0, 4'h0, 4'b0100);
        push_round(1, 8'h3F, 8'h3F, 8'hBF, 8'h3F, 1'b0);
        push_slot(2, 0, 8'h3F, 1'b0);
        push_ev(70, 8'h77, 4'b0001, 2'd0);
        push_slot(2, 1, 8'h3F, 1'b0);
        push_slot(2, 2, 8'hBF, 1'b0);
        push_slot(2, 3, 8'h3F, 1'b0);
        push_slot(3, 0, 8'h77, 1'b0);
        wait_cyc(32);
        mon_en = 1'b1;
        wait_cyc(68);
        do_write(2'd0, 4'hA, 1'b0);
        wr_bus.wr_addr = 2'd1; wr_bus.wr_data = 4'hF; wr_bus.wr_dp = 1'b1;
        drain("write_drain");

        // Reset mid-slot at scan_cnt=5, idx=2 (just after edge 21).
        do_reset();
        write_all(4'h8, 4'h8, 4'h8, 4'h8, 4'b0000);
        wait_cyc(21);
        chk("pre_reset_dig", {28'd0, DIG}, 32'h4);
        chk("pre_reset_seg", {24'd0, SEG}, 32'h7F);
        chk("pre_reset_cur", {30'd0, cur_digit}, 32'd2);
        reset = 1'b1;
        #1;
        chk("async_reset_seg", {24'd0, SEG}, 32'd0);
        chk("async_reset_dig", {28'd0, DIG}, 32'd0);
        chk("async_reset_cur", {30'd0, cur_digit}, 32'd0);
        push_round(0, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 1'b1);
        repeat (2) @(negedge clk_2);
        reset  = 1'b0;
        mon_en = 1'b1;
        drain("post_reset_drain");

        // Blink on digit 0, all codes 8.
        do_reset();
        blink_mask = 4'b0001;
        write_all(4'h8, 4'h8, 4'h8, 4'h8, 4'b0000);
`ifdef SEG7_BLINK_EN
        push_round(1, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b0);
        push_round(2, 8'h00, 8'h7F, 8'h7F, 8'h7F, 1'b0);
        push_round(3, 8'h00, 8'h7F, 8'h7F, 8'h7F, 1'b0);
        push_round(4, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b0);
`else
        for (int r = 1; r <= 4; r++) push_round(r, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b0);
`endif
        wait_cyc(32);
        mon_en = 1'b1;
        drain("blink_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exhausted, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
